// File: rtl/bram_1p_byte_en_ctrl.sv
// Request-side controller for a single-port byte-enable BRAM.
// Accepts read/write requests over valid/ready, drives the BRAM pins
// directly from the accepted request, and returns read data in order
// through a small response FIFO guarded by a credit scheme.
module bram_1p_byte_en_ctrl #(
    parameter int NB_COL        = 2,
    parameter int COL_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 3,
    parameter int RSP_DEPTH     = 3
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic                               req_valid_i,
    output logic                               req_ready_o,
    input  logic [NB_COL-1:0]                  req_we_i,
    input  logic [RAM_ADDR_BITS-1:0]           req_addr_i,
    input  logic [NB_COL*COL_WIDTH-1:0]        req_wdata_i,
    output logic                               rsp_valid_o,
    input  logic                               rsp_ready_i,
    output logic [NB_COL*COL_WIDTH-1:0]        rsp_rdata_o,
    output logic                               mem_en_o,
    output logic [NB_COL-1:0]                  mem_we_o,
    output logic [RAM_ADDR_BITS-1:0]           mem_addr_o,
    output logic [NB_COL*COL_WIDTH-1:0]        mem_data_o,
    input  logic [NB_COL*COL_WIDTH-1:0]        mem_data_i,
    output logic [$clog2(RSP_DEPTH+1)-1:0]     rsp_count_o
);

    localparam int DW     = NB_COL * COL_WIDTH;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W  = $clog2(RSP_DEPTH);
    localparam int USED_W = CNT_W + 1;

    logic              rdInflight_q, rdInflight_d;
    logic [CNT_W-1:0]  rspCount_q,   rspCount_d;
    logic [PTR_W-1:0]  wrPtr_q,      wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q,      rdPtr_d;
    logic [DW-1:0]     fifoMem_q [RSP_DEPTH];

    logic              isWrite;
    logic              credit;
    logic              fire;
    logic              rdFire;
    logic              push;
    logic              pop;
    logic [USED_W-1:0] used;

    // Circular pointer advance, wrapping at the FIFO depth.
    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RSP_DEPTH - 1)) begin
            ptrInc = '0;
        end else begin
            ptrInc = p + 1'b1;
        end
    endfunction

    // Request acceptance: writes never need a FIFO slot, reads need a credit
    // counted against both stored responses and the one read in flight.
    always_comb begin
        isWrite     = |req_we_i;
        used        = USED_W'(rspCount_q) + USED_W'(rdInflight_q);
        credit      = (used < USED_W'(RSP_DEPTH));
        req_ready_o = rstn_i & (isWrite | credit);
        fire        = req_valid_i & req_ready_o;
        rdFire      = fire & ~isWrite;
    end

    // BRAM pins follow the accepted request in the same cycle.
    always_comb begin
        mem_en_o   = fire;
        mem_we_o   = fire ? req_we_i : '0;
        mem_addr_o = req_addr_i;
        mem_data_o = req_wdata_i;
    end

    // Next-state for the read pipeline flag, FIFO pointers and occupancy.
    always_comb begin
        push         = rdInflight_q;
        pop          = rsp_valid_o & rsp_ready_i;
        rdInflight_d = rdFire;
        wrPtr_d      = push ? ptrInc(wrPtr_q) : wrPtr_q;
        rdPtr_d      = pop  ? ptrInc(rdPtr_q) : rdPtr_q;
        rspCount_d   = rspCount_q;
        case ({push, pop})
            2'b10:   rspCount_d = rspCount_q + 1'b1;
            2'b01:   rspCount_d = rspCount_q - 1'b1;
            default: rspCount_d = rspCount_q;
        endcase
    end

    // Control state with synchronous active-low reset; discards in-flight reads.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rdInflight_q <= 1'b0;
            rspCount_q   <= '0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
        end else begin
            rdInflight_q <= rdInflight_d;
            rspCount_q   <= rspCount_d;
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
        end
    end

    // FIFO storage captures BRAM read data one cycle after the read was issued.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= mem_data_i;
        end
    end

    // Response channel: head of FIFO, forced to zero whenever nothing is held.
    always_comb begin
        rsp_valid_o = (rspCount_q != '0);
        rsp_rdata_o = rsp_valid_o ? fifoMem_q[rdPtr_q] : '0;
        rsp_count_o = rspCount_q;
    end

endmodule

// File: tb/tb_bram_1p_byte_en_ctrl.sv
// Directed testbench for bram_1p_byte_en_ctrl with a behavioural
// byte-enable BRAM (1-cycle read latency) attached to the memory port.
module tb_bram_1p_byte_en_ctrl;

    logic        clk_i;
    logic        rstn_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_we_i;
    logic [2:0]  req_addr_i;
    logic [15:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [15:0] rsp_rdata_o;
    logic        mem_en_o;
    logic [1:0]  mem_we_o;
    logic [2:0]  mem_addr_o;
    logic [15:0] mem_data_o;
    logic [15:0] mem_data_i;
    logic [1:0]  rsp_count_o;

    int nVectors;
    int nMiscompares;

    logic [15:0] ram [8];

    bram_1p_byte_en_ctrl #(
        .NB_COL(2), .COL_WIDTH(8), .RAM_ADDR_BITS(3), .RSP_DEPTH(3)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .rsp_count_o(rsp_count_o)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Behavioural single-port BRAM with per-byte write enables and registered read.
    always @(posedge clk_i) begin
        if (mem_en_o) begin
            if (mem_we_o[0]) ram[mem_addr_o][7:0]  <= mem_data_o[7:0];
            if (mem_we_o[1]) ram[mem_addr_o][15:8] <= mem_data_o[15:8];
            mem_data_i <= ram[mem_addr_o];
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] we, input logic [2:0] a,
                                 input logic [15:0] d, input logic rr);
        req_valid_i = v;
        req_we_i    = we;
        req_addr_i  = a;
        req_wdata_i = d;
        rsp_ready_i = rr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nVectors++;
        assert (observed === expected)
        else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Single read with immediate consumption; response expected two cycles later.
    task automatic readCheck(input logic [2:0] a, input logic [15:0] expData, input string tag);
        applyStimulus(1'b1, 2'b00, a, 16'h0000, 1'b1);
        checkOutput({tag, "_ready"}, req_ready_o, 1);
        tick();
        applyStimulus(1'b0, 2'b00, 3'd0, 16'h0000, 1'b1);
        checkOutput({tag, "_notyet"}, rsp_valid_o, 0);
        tick();
        checkOutput({tag, "_valid"}, rsp_valid_o, 1);
        checkOutput({tag, "_data"}, rsp_rdata_o, expData);
        tick();
        checkOutput({tag, "_drained"}, rsp_count_o, 0);
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;

        // Reset held for two cycles with a pending read.
        rstn_i = 1'b0;
        applyStimulus(1'b1, 2'b00, 3'd0, 16'h0000, 1'b1);
        tick();
        tick();
        checkOutput("rst_ready", req_ready_o, 0);
        checkOutput("rst_en", mem_en_o, 0);
        checkOutput("rst_valid", rsp_valid_o, 0);
        checkOutput("rst_count", rsp_count_o, 0);
        checkOutput("rst_rdata", rsp_rdata_o, 0);
        rstn_i = 1'b1;
        applyStimulus(1'b0, 2'b00, 3'd0, 16'h0000, 1'b1);
        tick();

        // Fill all eight words.
        for (int a = 0; a < 8; a++) begin
            applyStimulus(1'b1, 2'b11, 3'(a), 16'h1100 + 16'(a), 1'b1);
            checkOutput("fill_ready", req_ready_o, 1);
            checkOutput("fill_we", mem_we_o, 2'b11);
            tick();
        end

        // Eight back-to-back reads; responses stream out starting two cycles later.
        for (int i = 0; i <= 10; i++) begin
            if (i < 8) begin
                applyStimulus(1'b1, 2'b00, 3'(i), 16'h0000, 1'b1);
                checkOutput("b2b_ready", req_ready_o, 1);
            end else begin
                applyStimulus(1'b0, 2'b00, 3'd0, 16'h0000, 1'b1);
            end
            checkOutput("b2b_valid", rsp_valid_o, (i >= 2 && i < 10) ? 1 : 0);
            if (i >= 2 && i < 10) begin
                checkOutput("b2b_data", rsp_rdata_o, 16'h1100 + 16'(i - 2));
            end
            tick();
        end

        // Byte enables: low byte, then high byte.
        applyStimulus(1'b1, 2'b01, 3'd3, 16'hABCD, 1'b1);
        tick();
        readCheck(3'd3, 16'h11CD, "be_low");
        applyStimulus(1'b1, 2'b10, 3'd3, 16'hEE00, 1'b1);
        tick();
        readCheck(3'd3, 16'hEECD, "be_high");

        // Restore word 3 before the backpressure sequence.
        applyStimulus(1'b1, 2'b11, 3'd3, 16'h1103, 1'b1);
        tick();

        // Backpressure: three reads accepted, the fourth stalls.
        applyStimulus(1'b1, 2'b00, 3'd0, 16'h0000, 1'b0);
        checkOutput("bp_rd0_ready", req_ready_o, 1);
        tick();
        applyStimulus(1'b1, 2'b00, 3'd1, 16'h0000, 1'b0);
        checkOutput("bp_rd1_ready", req_ready_o, 1);
        tick();
        applyStimulus(1'b1, 2'b00, 3'd2, 16'h0000, 1'b0);
        checkOutput("bp_rd2_ready", req_ready_o, 1);
        tick();
        applyStimulus(1'b1, 2'b00, 3'd3, 16'h0000, 1'b0);
        checkOutput("bp_rd3_stall", req_ready_o, 0);
        checkOutput("bp_rd3_en", mem_en_o, 0);
        checkOutput("bp_hold_c3", rsp_rdata_o, 16'h1100);
        tick();
        checkOutput("bp_full_ready", req_ready_o, 0);
        checkOutput("bp_count", rsp_count_o, 3);
        checkOutput("bp_hold_c4", rsp_rdata_o, 16'h1100);

        // Write while the FIFO is full is accepted immediately.
        applyStimulus(1'b1, 2'b11, 3'd7, 16'h5A5A, 1'b0);
        checkOutput("wfull_ready", req_ready_o, 1);
        checkOutput("wfull_en", mem_en_o, 1);
        checkOutput("wfull_we", mem_we_o, 2'b11);
        tick();

        // Release backpressure; the pop only frees a credit next cycle.
        applyStimulus(1'b1, 2'b00, 3'd3, 16'h0000, 1'b1);
        checkOutput("rel_c5_ready", req_ready_o, 0);
        checkOutput("rel_c5_data", rsp_rdata_o, 16'h1100);
        tick();
        applyStimulus(1'b1, 2'b00, 3'd3, 16'h0000, 1'b1);
        checkOutput("rel_c6_ready", req_ready_o, 1);
        checkOutput("rel_c6_data", rsp_rdata_o, 16'h1101);
        tick();
        applyStimulus(1'b1, 2'b00, 3'd4, 16'h0000, 1'b1);
        checkOutput("rel_c7_ready", req_ready_o, 1);
        checkOutput("rel_c7_data", rsp_rdata_o, 16'h1102);
        tick();
        applyStimulus(1'b0, 2'b00, 3'd0, 16'h0000, 1'b1);
        checkOutput("rel_c8_data", rsp_rdata_o, 16'h1103);
        tick();
        checkOutput("rel_c9_valid", rsp_valid_o, 1);
        checkOutput("rel_c9_data", rsp_rdata_o, 16'h1104);
        tick();
        checkOutput("rel_c10_valid", rsp_valid_o, 0);

        // The write made during the stall is visible.
        readCheck(3'd7, 16'h5A5A, "wfull_rd");

        // Reset on the cycle after a read is accepted discards it.
        applyStimulus(1'b1, 2'b00, 3'd1, 16'h0000, 1'b1);
        checkOutput("mid_ready", req_ready_o, 1);
        tick();
        rstn_i = 1'b0;
        applyStimulus(1'b1, 2'b00, 3'd1, 16'h0000, 1'b1);
        checkOutput("mid_rst_ready", req_ready_o, 0);
        checkOutput("mid_rst_en", mem_en_o, 0);
        tick();
        rstn_i = 1'b1;
        applyStimulus(1'b0, 2'b00, 3'd0, 16'h0000, 1'b1);
        checkOutput("mid_post_valid", rsp_valid_o, 0);
        checkOutput("mid_post_count", rsp_count_o, 0);
        tick();
        checkOutput("mid_post2_valid", rsp_valid_o, 0);
        readCheck(3'd2, 16'h1102, "mid_rd");

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
